// File: rtl/mux_rezultati_pipe.sv
// Registered N:1 ALU result selector with a valid/ready handshake and a 2-entry skid buffer.
// Define MUX_FLAGS_EN to add the stored Zero/Neg result flags and their output ports.
module mux_rezultati_pipe #(
  parameter  int W  = 16,
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            In_valid,
  output logic            In_ready,
  input  logic [N*W-1:0]  A,
  input  logic [SW-1:0]   S,
  output logic            Out_valid,
  input  logic            Out_ready,
  output logic [W-1:0]    Dalja
`ifdef MUX_FLAGS_EN
  ,
  output logic            Zero,
  output logic            Neg
`endif
);

`ifdef MUX_FLAGS_EN
  localparam int FW = 2;
`else
  localparam int FW = 0;
`endif
  localparam int DW = W + FW;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t          r_state, w_state_next;
  logic            r_out_valid, r_in_ready;
  logic [DW-1:0]   r_main, r_skid;
  logic [W-1:0]    w_sel;
  logic [DW-1:0]   w_word;
  logic            w_accept;
  logic            w_main_from_in, w_main_from_skid, w_skid_from_in;

  // Flags travel with the word, so they are computed once here and never re-derived from A.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (32'(S) == k) w_sel = A[k*W +: W];
    end
`ifdef MUX_FLAGS_EN
    w_word = {w_sel[W-1], (w_sel == '0), w_sel};
`else
    w_word = w_sel;
`endif
  end

  assign w_accept = In_valid && r_in_ready;

  always_comb begin
    w_state_next     = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_main_from_in = 1'b1;
          w_state_next   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_accept && Out_ready) begin
          w_main_from_in = 1'b1;
        end else if (w_accept) begin
          w_skid_from_in = 1'b1;
          w_state_next   = ST_FULL;
        end else if (Out_ready) begin
          w_state_next   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (Out_ready) begin
          w_main_from_skid = 1'b1;
          w_state_next     = ST_ONE;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      // NOTE: both data registers are cleared so no stale result survives a reset.
      r_main      <= '0;
      r_skid      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= (w_state_next != ST_EMPTY);
      r_in_ready  <= (w_state_next != ST_FULL);
      if (w_main_from_in)        r_main <= w_word;
      else if (w_main_from_skid) r_main <= r_skid;
      if (w_skid_from_in)        r_skid <= w_word;
    end
  end

  assign In_ready  = r_in_ready;
  assign Out_valid = r_out_valid;
  assign Dalja     = r_main[W-1:0];
`ifdef MUX_FLAGS_EN
  assign Zero      = r_main[W];
  assign Neg       = r_main[W+1];
`endif

endmodule

// File: tb/tb_mux_rezultati_pipe.sv
// Self-checking bench for mux_rezultati_pipe: directed vectors on an N=8 and an N=5 instance,
// then a random handshake run against a FIFO scoreboard.
module tb_mux_rezultati_pipe;

  localparam int W = 16;

  logic          Clock = 1'b0;
  logic          Reset;

  logic          in_valid, out_ready;
  logic [8*W-1:0] a;
  logic [2:0]    s;
  logic          in_ready, out_valid;
  logic [W-1:0]  dalja;

  logic          in_valid5, out_ready5;
  logic [5*W-1:0] a5;
  logic [2:0]    s5;
  logic          in_ready5, out_valid5;
  logic [W-1:0]  dalja5;

`ifdef MUX_FLAGS_EN
  logic zero, neg, zero5, neg5;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  mux_rezultati_pipe #(.W(W), .N(8)) u_dut8 (
    .Clock(Clock), .Reset(Reset), .In_valid(in_valid), .In_ready(in_ready),
    .A(a), .S(s), .Out_valid(out_valid), .Out_ready(out_ready), .Dalja(dalja)
`ifdef MUX_FLAGS_EN
    , .Zero(zero), .Neg(neg)
`endif
  );

  mux_rezultati_pipe #(.W(W), .N(5)) u_dut5 (
    .Clock(Clock), .Reset(Reset), .In_valid(in_valid5), .In_ready(in_ready5),
    .A(a5), .S(s5), .Out_valid(out_valid5), .Out_ready(out_ready5), .Dalja(dalja5)
`ifdef MUX_FLAGS_EN
    , .Zero(zero5), .Neg(neg5)
`endif
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  logic [W-1:0] q_exp[$];
  logic [W-1:0] exp_word, prev_dalja;
  logic         prev_stall;
  int           budget;

  initial begin
    Reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; s = '0;
    in_valid5 = 1'b0; out_ready5 = 1'b1; a5 = '0; s5 = '0;
    #12;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_in_ready",  16'(in_ready),  16'd1);
    chk("rst_dalja",     dalja,          16'h0000);
    @(negedge Clock);
    Reset = 1'b0;
    tick();

    // Select sweep: A[k] = 0x1111*(k+1), back-to-back accepts with Out_ready=1.
    for (int k = 0; k < 8; k++) a[k*W +: W] = 16'(16'h1111 * (k + 1));
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      s = 3'(k);
      tick();
      chk($sformatf("sweep_dalja_%0d", k), dalja, 16'(16'h1111 * (k + 1)));
      chk($sformatf("sweep_valid_%0d", k), 16'(out_valid), 16'd1);
      chk($sformatf("sweep_ready_%0d", k), 16'(in_ready), 16'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("sweep_drained", 16'(out_valid), 16'd0);

    // Stall / skid.
    out_ready = 1'b0;
    s = 3'd0;
    a[0 +: W] = 16'h00AA;
    in_valid = 1'b1;
    tick();
    chk("skid_first_dalja", dalja, 16'h00AA);
    chk("skid_first_ready", 16'(in_ready), 16'd1);
    a[0 +: W] = 16'h00BB;
    tick();
    chk("skid_full_dalja", dalja, 16'h00AA);
    chk("skid_full_ready", 16'(in_ready), 16'd0);
    in_valid = 1'b0;
    tick();
    chk("skid_hold_dalja", dalja, 16'h00AA);
    chk("skid_hold_ready", 16'(in_ready), 16'd0);
    out_ready = 1'b1;
    tick();
    chk("skid_drain_dalja", dalja, 16'h00BB);
    chk("skid_drain_valid", 16'(out_valid), 16'd1);
    chk("skid_drain_ready", 16'(in_ready), 16'd1);
    tick();
    chk("skid_empty", 16'(out_valid), 16'd0);

    // Reset while FULL holds 0x1234 / 0x5678.
    out_ready = 1'b0;
    in_valid = 1'b1;
    a[0 +: W] = 16'h1234;
    tick();
    a[0 +: W] = 16'h5678;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_ready", 16'(in_ready), 16'd0);
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_ready", 16'(in_ready),  16'd1);
    chk("mid_rst_dalja", dalja,          16'h0000);
    @(negedge Clock);
    Reset = 1'b0;
    a[0 +: W] = 16'h0042;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_dalja", dalja, 16'h0042);
    chk("post_rst_valid", 16'(out_valid), 16'd1);
    in_valid = 1'b0;
    tick();
    chk("post_rst_no_stale", 16'(out_valid), 16'd0);

`ifdef MUX_FLAGS_EN
    // Flags ride with each word.
    a[0 +: W] = 16'h8000; a[W +: W] = 16'h0000; a[2*W +: W] = 16'h7FFF;
    in_valid = 1'b1;
    s = 3'd0; tick();
    chk("flag_8000_neg",  16'(neg),  16'd1);
    chk("flag_8000_zero", 16'(zero), 16'd0);
    s = 3'd1; tick();
    chk("flag_0000_neg",  16'(neg),  16'd0);
    chk("flag_0000_zero", 16'(zero), 16'd1);
    s = 3'd2; tick();
    chk("flag_7fff_neg",  16'(neg),  16'd0);
    chk("flag_7fff_zero", 16'(zero), 16'd0);
    in_valid = 1'b0;
    tick();
`endif

    // Out-of-range select on the N=5 instance: every real input is 0xFFFF.
    for (int k = 0; k < 5; k++) a5[k*W +: W] = 16'hFFFF;
    in_valid5 = 1'b1;
    s5 = 3'd4; tick();
    chk("n5_sel4", dalja5, 16'hFFFF);
    s5 = 3'd6; tick();
    chk("n5_sel6_dalja", dalja5, 16'h0000);
    chk("n5_sel6_valid", 16'(out_valid5), 16'd1);
`ifdef MUX_FLAGS_EN
    chk("n5_sel6_zero", 16'(zero5), 16'd1);
`endif
    s5 = 3'd5; tick();
    chk("n5_sel5_dalja", dalja5, 16'h0000);
    in_valid5 = 1'b0;
    tick();

    // Random handshake against a FIFO scoreboard.
    prev_stall = 1'b0;
    prev_dalja = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      s         = 3'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) a[k*W +: W] = 16'($urandom);
      #1;
      if (prev_stall) chk("rnd_stable", dalja, prev_dalja);
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          chk("rnd_spurious", 16'(out_valid), 16'd0);
        end else begin
          exp_word = q_exp.pop_front();
          chk("rnd_data", dalja, exp_word);
`ifdef MUX_FLAGS_EN
          chk("rnd_zero", 16'(zero), 16'(exp_word == '0));
          chk("rnd_neg",  16'(neg),  16'(exp_word[W-1]));
`endif
        end
      end
      if (in_valid && in_ready) q_exp.push_back(a[32'(s)*W +: W]);
      prev_stall = out_valid && !out_ready;
      prev_dalja = dalja;
      tick();
    end

    // Drain whatever is left, with a bounded cycle budget.
    in_valid = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while (q_exp.size() != 0 && budget < 8) begin
      #1;
      if (out_valid) begin
        exp_word = q_exp.pop_front();
        chk("rnd_tail", dalja, exp_word);
      end
      tick();
      budget++;
    end
    chk("rnd_left_in_model", 16'(q_exp.size()), 16'd0);
    chk("rnd_final_valid", 16'(out_valid), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_rezultati_pipe.md
# mux_rezultati_pipe

Parametrised, registered ALU result selector: the successor of the combinational 8:1 result mux. It selects one of `N` `W`-bit functional-unit results by an operation code. It registers the selected result behind a valid/ready handshake with a 2-entry skid buffer, so the execute stage can be stalled by writeback without losing a result. It sits between the ALU functional units (AND, SLTI, OR, XOR, ADD/ADDI, SUB/SUBI, SLL, SRA, ...) and the writeback/register-file stage.

## Interface
- `W`, default 16: result width in bits.
- `N`, default 8: number of result inputs, 2..16.
- `SW`, default `$clog2(N)`, localparam: select width.
- `Clock`  in  1: sole clock, rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `In_valid`  in  1: `A`/`S` carry a valid operation this cycle.
- `In_ready`  out  1: block can accept an operation this cycle.
- `A`  in  N*W: flattened inputs. Input k occupies `A[k*W +: W]`.
- `S`  in  SW: selects input `S`. Encoding: 0 AND, 1 SLTI, 2 OR, 3 XOR, 4 ADD/ADDI, 5 SUB/SUBI, 6 SLL, 7 SRA.
- `Out_valid`  out  1: `Dalja`/flags hold a valid result.
- `Out_ready`  in  1: downstream accepts the result this cycle.
- `Dalja`  out  W: selected result.
- `Zero`  out  1: `Dalja == 0`. Present only under `MUX_FLAGS_EN`.
- `Neg`  out  1: `Dalja[W-1]`. Present only under `MUX_FLAGS_EN`.

## Operation
- Accept: `In_valid && In_ready` at a rising edge. The selected word is `A[S*W +: W]`; if `S >= N`, the selected word is all-zero.
- The selected word and its flags are computed combinationally at accept and stored. Nothing downstream recomputes from `A`.
- Storage: main register (drives outputs) plus skid register. Occupancy state machine:
  - EMPTY: `Out_valid`=0, `In_ready`=1. An accept loads main and goes to ONE.
  - ONE: `Out_valid`=1, `In_ready`=1.
    - Accept with `Out_ready`=1: main replaced by the new word; stay in ONE.
    - Accept with `Out_ready`=0: new word goes to skid; go to FULL.
    - No accept with `Out_ready`=1: go to EMPTY.
    - No accept with `Out_ready`=0: hold.
  - FULL: `Out_valid`=1, `In_ready`=0.
    - `Out_ready`=1: skid moves to main; go to ONE.
    - `Out_ready`=0: hold.
- `In_ready` is a registered output equal to "not FULL". It has no combinational path from `Out_ready`.
- Ordering is strictly FIFO. No result is dropped or duplicated.
- While `Out_valid`=1 and `Out_ready`=0, `Dalja`/`Zero`/`Neg` stay stable.
- Reset (any time, including mid-transfer): state EMPTY, both registers' contents cleared, all results discarded.
  - Reset values: `Out_valid`=0, `In_ready`=1, `Dalja`=0, `Zero`=0, `Neg`=0.
  - Operation resumes on the first rising edge after `Reset` deasserts.

## Timing
- Latency: accept at edge t makes the result visible on `Dalja` after edge t, i.e. one cycle.
- Throughput: one result per cycle while `Out_ready`=1.
- Simultaneous accept and drain in ONE: full throughput, no bubble.
- A single stall cycle (`Out_ready`=0) costs no input bubble. `In_ready` falls only after the skid register is filled.
- Drain from FULL: `In_ready` returns to 1 on the edge that moves skid to main.
- Combinational paths: only `A`/`S` to the register inputs. All outputs come straight from registers.

## Configuration
- `MUX_FLAGS_EN` defined:
  - `Zero` and `Neg` are stored alongside each word in both main and skid.
  - They follow the same handshake and ordering as `Dalja`.
- `MUX_FLAGS_EN` not defined:
  - `Zero`/`Neg` ports are absent and no flag storage is built.
  - Data path and handshake are otherwise identical.

## Test plan
- Select sweep, `W`=16, `N`=8: `A0`..`A7` = `0x1111`..`0x8888`; `S`=0..7 back-to-back, `Out_ready`=1. Required: `Dalja` = `0x1111`..`0x8888` on consecutive cycles, each one cycle after accept, `In_ready` always 1.
- Stall/skid: accept `0x00AA` then `0x00BB` with `Out_ready`=0. Required:
  - `Dalja` holds `0x00AA`; `In_ready`=0 after the second accept.
  - When `Out_ready`=1: `0x00AA`, then `0x00BB`; `In_ready`=1 again.
- Out-of-range select, `N`=5: `S`=6, `In_valid`=1. Required: `Dalja`=`0x0000`, `Zero`=1.
- Flags (`MUX_FLAGS_EN`): select `0x8000` → `Neg`=1, `Zero`=0. Select `0x0000` → `Zero`=1, `Neg`=0. Select `0x7FFF` → both 0.
- Reset mid-operation: with FULL holding `0x1234`/`0x5678`, assert `Reset` asynchronously between edges. Required:
  - Immediately `Out_valid`=0, `In_ready`=1, `Dalja`=0.
  - After release, the next accept of `0x0042` is the first result out.
- Random handshake: 10k cycles of random `In_valid`, `Out_ready`, `S`, `A`. Required: output stream equals the scoreboard of the accepted selections; `Dalja` stable while stalled.
